// File: rtl/pipe_arb_pkg.sv
// Shared types and defaults for the pipe enqueue arbiter.
package pipe_arb_pkg;

  localparam int unsigned PIPE_WIDTH = 144;
  localparam int unsigned DEF_NREQ   = 3;
  localparam int unsigned DEF_CNT_W  = 32;

  typedef logic [PIPE_WIDTH-1:0] pipe_word_t;

  // Fold an index that may exceed n by less than n back into 0..n-1.
  function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/pipe_enq_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first asserted req at or after ptr.
module rr_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Search ptr, ptr+1, ... mod NREQ and stop at the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDX_W'(rr_wrap(32'(ptr) + k, NREQ));
      if (en && !any && req[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
    if (any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_enq_arbiter.sv
// Round-robin arbiter sharing one pipe enqueue sink between NREQ serializers.
// Each requester has a 1-entry buffer; a registered output stage feeds the pipe.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module pipe_enq_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = PIPE_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req_enq__ENA,
  output logic [NREQ-1:0]       req_enq__RDY,
  input  logic [NREQ*WIDTH-1:0] req_enq_v,
  output logic                  pipe_enq__ENA,
  input  logic                  pipe_enq__RDY,
  output logic [WIDTH-1:0]      pipe_enq_v
`ifdef ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] stat_grant_cnt,
  output logic [CNT_W-1:0]      stat_stall_cnt
`endif
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Reject unsupported configurations at elaboration.
  if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("pipe_enq_arbiter: unsupported parameter set");
  end

  logic [NREQ-1:0]  in_full_q, in_full_d;
  logic [WIDTH-1:0] buf_q [NREQ];
  logic [WIDTH-1:0] buf_d [NREQ];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_word_q, out_word_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_ok;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;

  assign req_enq__RDY  = ~in_full_q;
  assign pipe_enq__ENA = out_valid_q & pipe_enq__RDY;
  assign pipe_enq_v    = out_word_q;
  assign load_ok       = !out_valid_q || pipe_enq__RDY;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (in_full_q),
    .ptr       (rr_ptr_q),
    .en        (load_ok),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Buffer fill, grant transfer into the output stage and pointer advance.
  always_comb begin
    in_full_d   = in_full_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    rr_ptr_d    = rr_ptr_q;
    // Only empty buffers accept; ENA on a full one is dropped.
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_enq__ENA[i] && !in_full_q[i]) begin
        in_full_d[i] = 1'b1;
        buf_d[i]     = req_enq_v[i*WIDTH +: WIDTH];
      end
    end
    // A granted buffer is always full, so it never collides with a fill above.
    if (grant_any) begin
      out_word_d  = buf_q[grant_idx];
      out_valid_d = 1'b1;
      in_full_d   = in_full_d & ~grant;
      rr_ptr_d    = IDX_W'(rr_wrap(32'(grant_idx) + 32'd1, NREQ));
    end else if (load_ok) begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath and control registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      in_full_q   <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      rr_ptr_q    <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      in_full_q   <= in_full_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      rr_ptr_q    <= rr_ptr_d;
      buf_q       <= buf_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt_q [NREQ];
  logic [CNT_W-1:0] grant_cnt_d [NREQ];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Per-requester grant count and backpressure stall count, both wrapping.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_cnt_d[i] = grant_cnt_q[i] + CNT_W'(1);
      end
    end
    if (out_valid_q && !pipe_enq__RDY) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else begin
      stall_cnt_q <= stall_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
    assign stat_grant_cnt[gi*CNT_W +: CNT_W] = grant_cnt_q[gi];
  end
  assign stat_stall_cnt = stall_cnt_q;
`endif

  // Requesters must only enqueue while their RDY is high.
  a_enq_protocol: assert property (@(posedge CLK) disable iff (!nRST)
    (req_enq__ENA & in_full_q) == '0)
    else $error("pipe_enq_arbiter: ENA while not RDY");

endmodule

// File: tb/tb_pipe_enq_arbiter.sv
// Self-checking bench for pipe_enq_arbiter (NREQ=3, WIDTH=144).
module tb_pipe_enq_arbiter;
  import pipe_arb_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 144;
  localparam int unsigned CW = 32;

  logic           CLK = 1'b0;
  logic           nRST = 1'b0;
  logic [N-1:0]   req_ena = '0;
  logic [N-1:0]   req_rdy;
  logic [N*W-1:0] req_v = '0;
  logic           p_ena;
  logic           p_rdy = 1'b0;
  logic [W-1:0]   p_v;
`ifdef ARB_STATS_EN
  logic [N*CW-1:0] s_grant;
  logic [CW-1:0]   s_stall;
`endif

  always #5 CLK = ~CLK;

  pipe_enq_arbiter #(.NREQ(N), .WIDTH(W), .CNT_W(CW)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .req_enq__ENA  (req_ena),
    .req_enq__RDY  (req_rdy),
    .req_enq_v     (req_v),
    .pipe_enq__ENA (p_ena),
    .pipe_enq__RDY (p_rdy),
    .pipe_enq_v    (p_v)
`ifdef ARB_STATS_EN
    ,
    .stat_grant_cnt(s_grant),
    .stat_stall_cnt(s_stall)
`endif
  );

  int nchecks = 0;
  int nerr    = 0;

  // Behavioural model: buffers, one output register, a rotating priority index.
  bit          mfull [N];
  pipe_word_t  mbuf  [N];
  bit          mov;
  pipe_word_t  mword;
  int          mptr;
  int unsigned mg [N];
  int unsigned mstall;
  pipe_word_t  sbq [N][$];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mfull[i] = 1'b0;
      mbuf[i]  = '0;
      mg[i]    = 0;
      sbq[i].delete();
    end
    mov = 1'b0; mword = '0; mptr = 0; mstall = 0;
  endtask

  function automatic logic [N-1:0] model_rdy();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = !mfull[i];
    return r;
  endfunction

  // Apply inputs at the falling edge and let them settle before sampling.
  task automatic drive(input bit rst, input logic [N-1:0] ena,
                       input logic [N*W-1:0] v, input logic prdy);
    @(negedge CLK);
    nRST = !rst; req_ena = ena; req_v = v; p_rdy = prdy;
    if (rst) model_reset();
    #1;
  endtask

  // Model effect of the coming rising edge.
  task automatic advance();
    int g;
    bit load_ok;
    pipe_word_t gw;
    if (!nRST) return;
    load_ok = !mov || p_rdy;
    if (mov && !p_rdy) mstall++;
    g = -1;
    gw = '0;
    if (load_ok) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && mfull[(mptr + k) % N]) g = (mptr + k) % N;
      end
    end
    if (g >= 0) gw = mbuf[g];
    for (int i = 0; i < N; i++) begin
      if (req_ena[i] && !mfull[i]) begin
        mfull[i] = 1'b1;
        mbuf[i]  = req_v[i*W +: W];
      end
    end
    if (g >= 0) begin
      mfull[g] = 1'b0;
      mword = gw; mov = 1'b1;
      mptr = (g + 1) % N;
      mg[g]++;
    end else if (load_ok) begin
      mov = 1'b0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_rdy"}, W'(req_rdy), W'(model_rdy()));
    check({tag, "_ena"}, W'(p_ena), W'(mov && p_rdy));
    check({tag, "_v"}, p_v, mword);
`ifdef ARB_STATS_EN
    for (int i = 0; i < N; i++) check({tag, "_gcnt"}, W'(s_grant[i*CW +: CW]), W'(mg[i]));
    check({tag, "_stall"}, W'(s_stall), W'(mstall));
`endif
  endtask

  function automatic logic [N*W-1:0] base_words(input logic [W-1:0] b);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = b + W'(i);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_word(input int id);
    return {8'(id), 8'h00, $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  typedef struct {
    bit           rst;
    logic [N-1:0] ena;
    logic         prdy;
    logic [W-1:0] base;
    logic [N-1:0] e_rdy;
    logic         e_ena;
    logic [W-1:0] e_v;
  } vec_t;

  vec_t vt [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pipe_word_t got [$];
    logic [N-1:0] ena;
    int id;
    // reset, single word, reset, three-way burst
    vt[0]  = '{1'b1, 3'b000, 1'b1, 144'h0,  3'b111, 1'b0, 144'h0};
    vt[1]  = '{1'b0, 3'b001, 1'b1, 144'hA5, 3'b111, 1'b0, 144'h0};
    vt[2]  = '{1'b0, 3'b000, 1'b1, 144'h0,  3'b110, 1'b0, 144'h0};
    vt[3]  = '{1'b0, 3'b000, 1'b1, 144'h0,  3'b111, 1'b1, 144'hA5};
    vt[4]  = '{1'b1, 3'b000, 1'b1, 144'h0,  3'b111, 1'b0, 144'h0};
    vt[5]  = '{1'b0, 3'b111, 1'b1, 144'h1,  3'b111, 1'b0, 144'h0};
    vt[6]  = '{1'b0, 3'b000, 1'b1, 144'h0,  3'b000, 1'b0, 144'h0};
    vt[7]  = '{1'b0, 3'b000, 1'b1, 144'h0,  3'b001, 1'b1, 144'h1};
    vt[8]  = '{1'b0, 3'b000, 1'b1, 144'h0,  3'b011, 1'b1, 144'h2};
    vt[9]  = '{1'b0, 3'b000, 1'b1, 144'h0,  3'b111, 1'b1, 144'h3};
    vt[10] = '{1'b0, 3'b000, 1'b1, 144'h0,  3'b111, 1'b0, 144'h3};

    model_reset();
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].rst, vt[i].ena, base_words(vt[i].base), vt[i].prdy);
      check($sformatf("vec%0d_rdy", i), W'(req_rdy), W'(vt[i].e_rdy));
      check($sformatf("vec%0d_ena", i), W'(p_ena), W'(vt[i].e_ena));
      check($sformatf("vec%0d_v", i), p_v, vt[i].e_v);
      advance();
    end
`ifdef ARB_STATS_EN
    for (int i = 0; i < N; i++) check("burst_gcnt", W'(s_grant[i*CW +: CW]), W'(1));
`endif

    // Backpressure: all three full, pipe stalled 10 cycles, then drain.
    drive(0, 3'b111, base_words(144'd11), 1'b1); compare_model("bp0"); advance();
    drive(0, 3'b000, '0, 1'b1);                  compare_model("bp1"); advance();
    drive(0, 3'b001, base_words(144'd14), 1'b0); compare_model("bp2"); advance();
    for (int c = 0; c < 9; c++) begin
      drive(0, 3'b000, '0, 1'b0);
      compare_model("bp_hold");
      check("bp_word_stable", p_v, W'(144'd11));
      check("bp_rdy_low", W'(req_rdy), W'(3'b000));
      advance();
    end
    for (int c = 0; c < 6; c++) begin
      drive(0, 3'b000, '0, 1'b1);
      compare_model("bp_drain");
      if (p_ena) got.push_back(p_v);
      advance();
    end
    check("bp_count", W'(got.size()), W'(4));
    if (got.size() == 4) begin
      check("bp_w0", got[0], W'(144'd11));
      check("bp_w1", got[1], W'(144'd12));
      check("bp_w2", got[2], W'(144'd13));
      check("bp_w3", got[3], W'(144'd14));
    end
`ifdef ARB_STATS_EN
    check("bp_stall_cnt", W'(s_stall), W'(10));
`endif

    // Reset while all buffers are full and the output holds a word.
    drive(0, model_rdy(), base_words(144'd21), 1'b0); advance();
    drive(0, 3'b000, '0, 1'b0); advance();
    drive(0, model_rdy(), base_words(144'd31), 1'b0); advance();
    drive(0, 3'b000, '0, 1'b0); compare_model("pre_rst"); advance();
    drive(1, 3'b000, '0, 1'b1);
    check("rst_rdy", W'(req_rdy), W'(3'b111));
    check("rst_ena", W'(p_ena), W'(0));
    check("rst_v", p_v, '0);
    advance();
    for (int c = 0; c < 5; c++) begin
      drive(0, 3'b000, '0, 1'b1);
      check("post_rst_no_word", W'(p_ena), W'(0));
      advance();
    end

    // Randomized traffic checked cycle by cycle plus an ordering scoreboard.
    for (int c = 0; c < 3000; c++) begin
      logic [N*W-1:0] v;
      ena = N'($urandom()) & model_rdy();
      for (int i = 0; i < N; i++) v[i*W +: W] = rnd_word(i);
      drive(0, ena, v, ($urandom_range(0, 3) != 0));
      compare_model("rnd");
      if (p_ena) begin
        id = int'(p_v[W-1 -: 8]);
        if (id < N && sbq[id].size() > 0) check("sb_order", p_v, sbq[id].pop_front());
        else check("sb_unexpected", p_v, '0);
      end
      for (int i = 0; i < N; i++) if (ena[i]) sbq[i].push_back(v[i*W +: W]);
      advance();
    end
    for (int c = 0; c < 10; c++) begin
      drive(0, 3'b000, '0, 1'b1);
      compare_model("flush");
      if (p_ena) begin
        id = int'(p_v[W-1 -: 8]);
        if (id < N && sbq[id].size() > 0) check("sb_order", p_v, sbq[id].pop_front());
        else check("sb_unexpected", p_v, '0);
      end
      advance();
    end
    for (int i = 0; i < N; i++) check("sb_leftover", W'(sbq[i].size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
